pdecoder_hold: RTL and testbench

Sequential decoder on the receive side of the 4-line priority-encoder link. It accepts encoded codes (y, v) through a valid/ready handshake and buffers them in a 2-entry FIFO. Each code is re-expanded to a one-hot 4-bit line vector, and that vector is held on the output for a programmable number of cycles. It sits downstream of the priority encoder, where the downstream logic needs one-hot line strobes of fixed width rather than codes.

---
 rtl/pdec_pkg.sv | 22 ++
 rtl/pdecoder_hold_if.sv | 24 ++
 rtl/pdec_fifo2.sv | 49 ++++
 rtl/pdecoder_hold.sv | 107 ++++++++++
 tb/tb_pdecoder_hold.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pdec_pkg.sv
// Shared types and helpers for the 4-line priority-encoder link decoder.
// The onehot4 helper is reused by encoder/decoder benches as a reference model.
package pdec_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic       v;
    logic [1:0] y;
  } entry_t;

  localparam int FIFO_DEPTH = 2;

  // A code with v=0 is the "no line active" frame, whatever y says.
  function automatic logic [3:0] onehot4(input logic v, input logic [1:0] y);
    return v ? (4'b0001 << y) : 4'b0000;
  endfunction

endpackage

// File: rtl/pdecoder_hold_if.sv
// Code-input handshake and decoded-line output bundle of pdecoder_hold.
// master drives codes into the decoder; slave is the decoder side.
interface pdecoder_hold_if;

  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_y;
  logic       in_v;
  logic [3:0] out_d;
  logic       out_valid;
  logic       busy;
  logic       code_err;

  modport master (
    output in_valid, in_y, in_v,
    input  in_ready, out_d, out_valid, busy, code_err
  );

  modport slave (
    input  in_valid, in_y, in_v,
    output in_ready, out_d, out_valid, busy, code_err
  );

endinterface

// File: rtl/pdec_fifo2.sv
// Two-entry synchronous FIFO of encoded codes with a registered occupancy count.
// Push while full and pop while empty are ignored.
module pdec_fifo2
  import pdec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  entry_t     wr_data,
  output entry_t     rd_data,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  entry_t     mem [FIFO_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count_q;
  logic       push_ok;
  logic       pop_ok;

  assign full    = (count_q == 2'(FIFO_DEPTH));
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  // NOTE: storage is not reset; count_q gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pdecoder_hold.sv
// Receive-side decoder: buffers (y, v) codes and drives each as a one-hot
// line vector for HOLD_CYCLES consecutive cycles, frames back-to-back.
module pdecoder_hold
  import pdec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input logic          clk,
  input logic          rst,
  pdecoder_hold_if.slave bus
);

  localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] hcnt_q, hcnt_d;
  logic [3:0] out_d_q, out_d_d;
  logic       out_valid_q, out_valid_d;
  logic       code_err_q;

  entry_t     head;
  logic       fifo_full;
  logic       fifo_empty;
  logic [1:0] fifo_count;
  logic       pop;
  logic       drop_frame;
  logic       accept;

  assign accept = bus.in_valid & ~fifo_full;

  pdec_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.in_valid),
    .pop     (pop),
    .wr_data ('{v: bus.in_v, y: bus.in_y}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hcnt_q      <= 4'd0;
      out_d_q     <= 4'd0;
      out_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      out_d_q     <= out_d_d;
      out_valid_q <= out_valid_d;
      if (accept && !bus.in_v && bus.in_y != 2'd0) code_err_q <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    pop        = 1'b0;
    drop_frame = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          hcnt_d  = HOLD_RELOAD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hcnt_q != 4'd0) begin
          hcnt_d = hcnt_q - 4'd1;
        end else if (!fifo_empty) begin
          // Next frame starts on the very next cycle: no gap between codes.
          pop    = 1'b1;
          hcnt_d = HOLD_RELOAD;
        end else begin
          drop_frame = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d_d     = out_d_q;
    out_valid_d = out_valid_q;
    if (pop) begin
      out_d_d     = onehot4(head.v, head.y);
      out_valid_d = 1'b1;
    end else if (drop_frame) begin
      out_d_d     = 4'd0;
      out_valid_d = 1'b0;
    end
  end

  assign bus.in_ready  = ~fifo_full;
  assign bus.out_d     = out_d_q;
  assign bus.out_valid = out_valid_q;
  assign bus.code_err  = code_err_q;
  assign bus.busy      = (state_q == HOLD) | (fifo_count != 2'd0);

endmodule

// File: tb/tb_pdecoder_hold.sv
// Directed bench for pdecoder_hold: a HOLD_CYCLES=4 instance for framing and
// stream cases, a HOLD_CYCLES=1 instance for full-rate throughput.
module tb_pdecoder_hold;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pdecoder_hold_if bus4 ();
  pdecoder_hold_if bus1 ();

  pdecoder_hold #(.HOLD_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  pdecoder_hold #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic       v;
    logic [1:0] y;
    logic [3:0] exp_d;
    logic       exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle4(input string name);
    check({name, "_d"},     bus4.out_d, 4'b0000);
    check({name, "_valid"}, {3'b0, bus4.out_valid}, 4'd0);
    check({name, "_ready"}, {3'b0, bus4.in_ready}, 4'd1);
    check({name, "_busy"},  {3'b0, bus4.busy}, 4'd0);
  endtask

  // Independent reference: explicit decode table rather than a shift.
  function automatic logic [3:0] ref_dec(input logic v, input logic [1:0] y);
    logic [3:0] r;
    r = 4'b0000;
    if (v) begin
      case (y)
        2'd0: r = 4'b0001;
        2'd1: r = 4'b0010;
        2'd2: r = 4'b0100;
        default: r = 4'b1000;
      endcase
    end
    return r;
  endfunction

  logic saw_block;
  int   drv_guard;

  initial begin
    vecs[0] = '{v: 1'b1, y: 2'd0, exp_d: 4'b0001, exp_err: 1'b0};
    vecs[1] = '{v: 1'b1, y: 2'd1, exp_d: 4'b0010, exp_err: 1'b0};
    vecs[2] = '{v: 1'b1, y: 2'd2, exp_d: 4'b0100, exp_err: 1'b0};
    vecs[3] = '{v: 1'b1, y: 2'd3, exp_d: 4'b1000, exp_err: 1'b0};
    vecs[4] = '{v: 1'b0, y: 2'd0, exp_d: 4'b0000, exp_err: 1'b0};
    vecs[5] = '{v: 1'b0, y: 2'd3, exp_d: 4'b0000, exp_err: 1'b1};
    vecs[6] = '{v: 1'b1, y: 2'd1, exp_d: 4'b0010, exp_err: 1'b1};
    vecs[7] = '{v: 1'b0, y: 2'd1, exp_d: 4'b0000, exp_err: 1'b1};

    bus4.in_valid = 1'b0; bus4.in_v = 1'b0; bus4.in_y = 2'd0;
    bus1.in_valid = 1'b0; bus1.in_v = 1'b0; bus1.in_y = 2'd0;

    // Reset for two cycles, then one idle cycle; outputs must sit at reset values.
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      if (c == 1) begin
        @(negedge clk);
        rst = 1'b0;
      end else begin
        @(negedge clk);
      end
      check_idle4("reset");
      check("reset_err", {3'b0, bus4.code_err}, 4'd0);
      check("reset1_valid", {3'b0, bus1.out_valid}, 4'd0);
      check("reset1_ready", {3'b0, bus1.in_ready}, 4'd1);
    end

    // Single codes: accept at edge k, frame visible after edges k+1..k+4, idle after k+5.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("tbl_ready", {3'b0, bus4.in_ready}, 4'd1);
      bus4.in_valid = 1'b1; bus4.in_v = vecs[i].v; bus4.in_y = vecs[i].y;
      @(negedge clk);
      bus4.in_valid = 1'b0;
      check("tbl_latency_valid", {3'b0, bus4.out_valid}, 4'd0);
      check("tbl_latency_busy", {3'b0, bus4.busy}, 4'd1);
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        check("tbl_d", bus4.out_d, vecs[i].exp_d);
        check("tbl_valid", {3'b0, bus4.out_valid}, 4'd1);
      end
      check("tbl_err", {3'b0, bus4.code_err}, {3'b0, vecs[i].exp_err});
      @(negedge clk);
      check_idle4("tbl_end");
    end

    // Continuous stream y=0..3: contiguous 4-cycle frames, in_ready drops while full.
    saw_block = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          bus4.in_valid = 1'b1; bus4.in_v = 1'b1; bus4.in_y = 2'(i);
          drv_guard = 0;
          while (!bus4.in_ready && drv_guard < 50) begin
            saw_block = 1'b1;
            @(negedge clk);
            drv_guard++;
          end
          check("stream_accept_bound", {3'b0, drv_guard < 50}, 4'd1);
          @(posedge clk);
        end
        @(negedge clk);
        bus4.in_valid = 1'b0;
      end
      begin
        int g;
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!bus4.out_valid && g < 30);
        check("stream_start_bound", {3'b0, g < 30}, 4'd1);
        for (int k = 0; k < 16; k++) begin
          if (k > 0) @(negedge clk);
          check("stream_d", bus4.out_d, ref_dec(1'b1, 2'(k / 4)));
          check("stream_valid", {3'b0, bus4.out_valid}, 4'd1);
        end
        @(negedge clk);
        check_idle4("stream_end");
      end
    join
    check("stream_ready_dropped", {3'b0, saw_block}, 4'd1);

    // HOLD_CYCLES=1: one code per cycle, one-cycle frames, never back-pressured.
    for (int c = 0; c < 19; c++) begin
      logic       cv;
      logic [1:0] cy;
      @(negedge clk);
      check("rate_ready", {3'b0, bus1.in_ready}, 4'd1);
      if (c == 1) check("rate_first_valid", {3'b0, bus1.out_valid}, 4'd0);
      if (c >= 2 && c <= 17) begin
        cv = ((c - 2) % 5) != 4;
        cy = 2'((c - 2) % 4);
        check("rate_d", bus1.out_d, ref_dec(cv, cy));
        check("rate_valid", {3'b0, bus1.out_valid}, 4'd1);
      end
      if (c == 18) begin
        check("rate_end_valid", {3'b0, bus1.out_valid}, 4'd0);
        check("rate_end_busy", {3'b0, bus1.busy}, 4'd0);
      end
      if (c < 16) begin
        bus1.in_valid = 1'b1;
        bus1.in_v     = (c % 5) != 4;
        bus1.in_y     = 2'(c % 4);
      end else begin
        bus1.in_valid = 1'b0;
      end
    end

    // Reset mid-hold with a full FIFO and code_err set: everything is discarded.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus4.in_valid = 1'b1;
      bus4.in_v     = (i != 1);
      bus4.in_y     = (i == 0) ? 2'd1 : (i == 1) ? 2'd2 : 2'd3;
    end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    check("midrst_pre_full", {3'b0, bus4.in_ready}, 4'd0);
    check("midrst_pre_d", bus4.out_d, 4'b0010);
    check("midrst_pre_err", {3'b0, bus4.code_err}, 4'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle4("midrst");
    check("midrst_err", {3'b0, bus4.code_err}, 4'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("midrst_no_stale", {3'b0, bus4.out_valid}, 4'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
